// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants, write-back entry type and helpers
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
  // x0 is hardwired, so it never shows up as busy
  function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] rd);
    return (NUM_REGS'(1) << rd) & ~NUM_REGS'(1);
  endfunction
endpackage

// File: rtl/regfile_writeback_queue_wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO of write-back entries exposing storage and per-slot valid bits
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  wb_entry_t push_data,
  input  logic pop,
  output wb_entry_t head,
  output logic [CW-1:0] count,
  output logic [DEPTH-1:0] valid,
  output wb_entry_t entries [DEPTH]
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  always_comb begin
    head_d = head_q + PW'(pop);
    tail_d = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    mem_d = mem_q;
    if (push) mem_d[tail_q] = push_data;
  end
  // a slot is live when its distance from head (mod DEPTH) is below count
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, PW'(PW'(i) - head_q)} < count_q;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  assign head = mem_q[head_q];
  assign count = count_q;
  assign entries = mem_q;
endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: arbitrates ALU/load results into a FIFO and drains one register write per cycle
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  output logic alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic mem_valid,
  output logic mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic WriteEnable,
  output logic [REG_ADDR_W-1:0] WritePort,
  output logic [XLEN-1:0] WriteData,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic queue_empty
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count;
  logic [DEPTH-1:0] valid;
  wb_entry_t entries [DEPTH];
  wb_entry_t head, in_entry;
  logic push, pop, not_full;
  logic we_q, we_d;
  logic [REG_ADDR_W-1:0] port_q, port_d;
  logic [XLEN-1:0] data_q, data_d;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .push_data(in_entry),
    .pop(pop),
    .head(head),
    .count(count),
    .valid(valid),
    .entries(entries)
  );
  // loads win; x0 results complete the handshake but are dropped
  always_comb begin
    not_full = count != CW'(DEPTH);
    mem_ready = !reset && not_full;
    alu_ready = !reset && not_full && !mem_valid;
    in_entry = mem_valid ? '{rd: mem_rd, data: mem_data} : '{rd: alu_rd, data: alu_data};
    push = ((mem_valid && mem_ready) || (alu_valid && alu_ready)) && in_entry.rd != '0;
    pop = count != '0;
    we_d = pop;
    port_d = pop ? head.rd : port_q;
    data_d = pop ? head.data : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0;
      port_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= we_d;
      port_q <= port_d;
      data_q <= data_d;
    end
  end
  always_comb begin
    busy_mask = we_q ? onehot_reg(port_q) : '0;
    for (int i = 0; i < DEPTH; i++) busy_mask = busy_mask | (valid[i] ? onehot_reg(entries[i].rd) : '0);
  end
  assign queue_empty = count == '0 && !we_q;
  assign WriteEnable = we_q;
  assign WritePort = port_q;
  assign WriteData = data_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: directed plus random stimulus against a queue-based write-back model
module tb_regfile_writeback_queue;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic reset, alu_valid, mem_valid, alu_ready, mem_ready, WriteEnable, queue_empty;
  logic [4:0] alu_rd, mem_rd, WritePort;
  logic [31:0] alu_data, mem_data, WriteData, busy_mask;
  int checks = 0;
  int errors = 0;
  wb_entry_t mq[$];
  logic m_we = 1'b0;
  logic [4:0] m_port = '0;
  logic [31:0] m_data = '0;
  logic [31:0] last7 = '0;
  always #5 clk = ~clk;
  regfile_writeback_queue dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .WriteEnable(WriteEnable), .WritePort(WritePort), .WriteData(WriteData),
    .busy_mask(busy_mask), .queue_empty(queue_empty)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    logic room;
    logic [31:0] exp_busy;
    wb_entry_t e;
    reset = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    @(negedge clk);
    room = mq.size() < 4;
    exp_busy = '0;
    foreach (mq[i]) exp_busy[mq[i].rd] = 1'b1;
    if (m_we) exp_busy[m_port] = 1'b1;
    check("mem_ready", mem_ready, !r && room);
    check("alu_ready", alu_ready, !r && room && !mv);
    check("WriteEnable", WriteEnable, m_we);
    check("WritePort", WritePort, m_port);
    check("WriteData", WriteData, m_data);
    check("busy_mask", busy_mask, exp_busy);
    check("queue_empty", queue_empty, mq.size() == 0 && !m_we);
    if (WriteEnable && WritePort == 5'd7) last7 = WriteData;
    if (r) begin
      mq.delete();
      m_we = 1'b0; m_port = '0; m_data = '0;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1'b1; m_port = e.rd; m_data = e.data;
      end else m_we = 1'b0;
      if (mv && room) begin
        if (mrd != 0) mq.push_back('{rd: mrd, data: md});
      end else if (av && room && ard != 0) mq.push_back('{rd: ard, data: ad});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask
  initial begin
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 32'h88);
    idle(1);
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(3);
    step(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    step(1'b0, 1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'd0);
    idle(3);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 32'h1111));
    idle(3);
    step(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5'd10, 32'(i), 1'b1, 5'(20 + i), 32'(100 + i));
    step(1'b1, 1'b1, 5'd11, 32'hBAD, 1'b1, 5'd12, 32'hBAD);
    idle(3);
    step(1'b0, 1'b1, 5'd7, 32'hAAAA, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 32'd0);
    idle(3);
    check("reg7_final", last7, 32'h5555);
    for (int i = 0; i < 3000; i++)
      step(($urandom % 64) == 0, 1'($urandom), 5'($urandom), $urandom,
           ($urandom % 3) == 0, 5'($urandom), $urandom);
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
